// File: rtl/shifter_pkg.sv
// Shared types for the pipelined barrel shifter, plus a bit-level reference
// function that benches can use as a golden model.
package shifter_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_mode_t;

    localparam int REF_W = 64;

    // n is the live data width (<= REF_W); bits above n are returned as zero.
    function automatic logic [REF_W-1:0] shift_ref(input logic [REF_W-1:0] a,
                                                   input int s,
                                                   input shift_mode_t mode,
                                                   input int n = 32);
        logic [REF_W-1:0] y;
        y = '0;
        for (int i = 0; i < REF_W; i++) begin
            if (i < n) begin
                case (mode)
                    SHIFT_SLL: y[i] = (i >= s) ? a[i-s] : 1'b0;
                    SHIFT_SRL: y[i] = (i + s < n) ? a[i+s] : 1'b0;
                    SHIFT_SRA: y[i] = (i + s < n) ? a[i+s] : a[n-1];
                    default:   y[i] = a[(i+s)%n];
                endcase
            end
        end
        return y;
    endfunction

endpackage

// File: rtl/shifter_stage.sv
// One barrel-shifter level: conditionally shifts by 2^K in any of the four modes.
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int N = 32,
    parameter int K = 0
) (
    input  logic [N-1:0] a,
    input  logic         en,
    input  logic [1:0]   mode,
    output logic [N-1:0] y
);

    localparam int SH = 1 << K;

    always_comb begin
        y = a;
        if (en) begin
            case (shift_mode_t'(mode))
                SHIFT_SLL: y = {a[N-1-SH:0], {SH{1'b0}}};
                SHIFT_SRL: y = {{SH{1'b0}}, a[N-1:SH]};
                SHIFT_SRA: y = {{SH{a[N-1]}}, a[N-1:SH]};
                default:   y = {a[SH-1:0], a[N-1:SH]};
            endcase
        end
    end

endmodule

// File: rtl/shifter_pipelined.sv
// Pipelined barrel shifter: S = log2(N) registered shift levels, globally stalled
// by the downstream ready so in-flight results are never reordered or dropped.
module shifter_pipelined
    import shifter_pkg::*;
#(
    parameter int N = 32,
    parameter int S = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         i_ready,
    input  logic [N-1:0] i_a,
    input  logic [S-1:0] i_s,
    input  logic [1:0]   i_mode,
    output logic         o_valid,
    input  logic         o_ready,
    output logic [N-1:0] o_y
);

    logic                advance;
    logic [S-1:0][N-1:0] stg_data;
    logic [S-1:0]        stg_vld;

    assign advance = !o_valid || o_ready;
    assign i_ready = advance;

    for (genvar k = 0; k < S; k++) begin : g_stage
        logic [N-1:0]   src_data;
        logic [N-1:0]   shifted;
        logic [N-1:0]   data_q, data_d;
        // Only the amount bits still needed downstream travel with the data.
        logic [S-k-1:0] src_amt;
        logic [1:0]     src_mode;
        logic           src_vld;
        logic           vld_q, vld_d;

        if (k == 0) begin : g_src
            assign src_data = i_a;
            assign src_amt  = i_s;
            assign src_mode = i_mode;
            assign src_vld  = i_valid;
        end else begin : g_src
            assign src_data = stg_data[k-1];
            assign src_amt  = g_stage[k-1].g_carry.amt_q;
            assign src_mode = g_stage[k-1].g_carry.mode_q;
            assign src_vld  = stg_vld[k-1];
        end

        shifter_stage #(.N(N), .K(k)) u_stage (
            .a    (src_data),
            .en   (src_amt[0]),
            .mode (src_mode),
            .y    (shifted)
        );

        always_comb begin
            data_d = data_q;
            vld_d  = vld_q;
            if (advance) begin
                data_d = shifted;
                vld_d  = src_vld;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_q <= '0;
                vld_q  <= 1'b0;
            end else begin
                data_q <= data_d;
                vld_q  <= vld_d;
            end
        end

        if (k < S-1) begin : g_carry
            logic [S-k-2:0] amt_q, amt_d;
            logic [1:0]     mode_q, mode_d;

            always_comb begin
                amt_d  = amt_q;
                mode_d = mode_q;
                if (advance) begin
                    amt_d  = src_amt[S-k-1:1];
                    mode_d = src_mode;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    amt_q  <= '0;
                    mode_q <= '0;
                end else begin
                    amt_q  <= amt_d;
                    mode_q <= mode_d;
                end
            end
        end

        assign stg_data[k] = data_q;
        assign stg_vld[k]  = vld_q;
    end

    assign o_y     = stg_data[S-1];
    assign o_valid = stg_vld[S-1];

endmodule

// File: tb/tb_shifter_pipelined.sv
// Bench for shifter_pipelined: N=32 and N=8 instances checked every cycle against
// an arithmetic shift model with an age-tracking scoreboard, plus directed vectors.
module tb_shifter_pipelined;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        v32, rdy32, ov32, ordy32;
    logic [31:0] a32, oy32;
    logic [4:0]  s32;
    logic [1:0]  m32;

    logic        v8, rdy8, ov8, ordy8;
    logic [7:0]  a8, oy8;
    logic [2:0]  s8;
    logic [1:0]  m8;

    shifter_pipelined #(.N(32)) dut32 (
        .clk(clk), .rst(rst), .i_valid(v32), .i_ready(rdy32), .i_a(a32), .i_s(s32),
        .i_mode(m32), .o_valid(ov32), .o_ready(ordy32), .o_y(oy32)
    );

    shifter_pipelined #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .i_valid(v8), .i_ready(rdy8), .i_a(a8), .i_s(s8),
        .i_mode(m8), .o_valid(ov8), .o_ready(ordy8), .o_y(oy8)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] y;
        int          age;
    } ent_t;

    ent_t        sb[2][$];
    bit          prev_stall[2];
    logic [31:0] prev_y[2];

    function automatic logic [31:0] model32(logic [31:0] a, int s, logic [1:0] m);
        logic [63:0] d;
        d = {a, a} >> s;
        case (m)
            2'd0:    return a << s;
            2'd1:    return a >> s;
            2'd2:    return $unsigned($signed(a) >>> s);
            default: return d[31:0];
        endcase
    endfunction

    function automatic logic [31:0] model8(logic [7:0] a, int s, logic [1:0] m);
        logic [15:0] d;
        logic [7:0]  r;
        d = {a, a} >> s;
        case (m)
            2'd0:    r = a << s;
            2'd1:    r = a >> s;
            2'd2:    r = $unsigned($signed(a) >>> s);
            default: r = d[7:0];
        endcase
        return {24'h0, r};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Entry age = advancing edges since acceptance; the head is visible at age lat.
    task automatic mon_step(int id, logic ov, logic [31:0] oy, logic ordy, logic iv,
                            logic ir, logic [31:0] exp_in, int lat);
        bit   ev;
        ent_t e;
        ev = (sb[id].size() > 0) && (sb[id][0].age >= lat);
        check($sformatf("o_valid[%0d]", id), {31'h0, ov}, {31'h0, ev});
        if (ev) check($sformatf("o_y[%0d]", id), oy, sb[id][0].y);
        check($sformatf("i_ready[%0d]", id), {31'h0, ir}, {31'h0, (!ov || ordy)});
        if (prev_stall[id]) check($sformatf("o_y_hold[%0d]", id), oy, prev_y[id]);
        prev_stall[id] = ov && !ordy;
        prev_y[id]     = oy;
        if (!ev || ordy) begin
            if (ev) void'(sb[id].pop_front());
            for (int i = 0; i < sb[id].size(); i++) sb[id][i].age++;
            if (iv) begin
                e.y   = exp_in;
                e.age = 0;
                sb[id].push_back(e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon_step(0, ov32, oy32, ordy32, v32, rdy32, model32(a32, int'(s32), m32), 4);
            mon_step(1, ov8, {24'h0, oy8}, ordy8, v8, rdy8, model8(a8, int'(s8), m8), 2);
        end
    end

    task automatic one32(string name, logic [31:0] a, int s, logic [1:0] m, logic [31:0] exp);
        int n;
        bit got;
        @(posedge clk); #1;
        a32 = a; s32 = 5'(s); m32 = m; v32 = 1'b1;
        @(posedge clk); #1;
        v32 = 1'b0;
        n = 0;
        got = 0;
        while (!got && n < 20) begin
            if (ov32) got = 1;
            else begin
                @(posedge clk); #1;
                n++;
            end
        end
        check({name, "_lat"}, 32'(n), 32'd4);
        check(name, oy32, exp);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        sb[0].delete();
        sb[1].delete();
        prev_stall[0] = 0;
        prev_stall[1] = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, cyc;
        bit tog;
        prev_stall[0] = 0;
        prev_stall[1] = 0;
        rst = 1'b1;
        v32 = 0; a32 = '0; s32 = '0; m32 = '0; ordy32 = 0;
        v8 = 0;  a8 = '0;  s8 = '0;  m8 = '0;  ordy8 = 0;

        // Reset state
        #3;
        check("rst_o_valid", {31'h0, ov32}, 32'd0);
        check("rst_o_y", oy32, 32'd0);
        check("rst_i_ready", {31'h0, rdy32}, 32'd1);
        check("rst_o_y8", {24'h0, oy8}, 32'd0);
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
        ordy32 = 1; ordy8 = 1;
        #1;
        check("rel_i_ready", {31'h0, rdy32}, 32'd1);

        // Directed vectors, one at a time
        one32("sll_1_31",  32'h0000_0001, 31, 2'd0, 32'h8000_0000);
        one32("sra_neg_4", 32'h8000_0000, 4,  2'd2, 32'hF800_0000);
        one32("srl_4",     32'h8000_0000, 4,  2'd1, 32'h0800_0000);
        one32("sra_pos_4", 32'h7000_0000, 4,  2'd2, 32'h0700_0000);
        one32("ror_8",     32'h1234_5678, 8,  2'd3, 32'h7812_3456);
        one32("ror_0",     32'h1234_5678, 0,  2'd3, 32'h1234_5678);
        one32("ror_31",    32'h1234_5678, 31, 2'd3, 32'h2468_ACF0);
        one32("sll_0",     32'hF0F0_F0F0, 0,  2'd0, 32'hF0F0_F0F0);
        one32("srl_16",    32'hFFFF_0000, 16, 2'd1, 32'h0000_FFFF);

        // Back-to-back stream with o_ready toggling every cycle
        sent = 0; cyc = 0; tog = 1;
        while (sent < 10 && cyc < 100) begin
            @(posedge clk); #1;
            ordy32 = tog; tog = !tog;
            a32 = 32'hA5C3_0F96 ^ (32'(sent) * 32'h0135_79BD);
            s32 = 5'(sent * 7);
            m32 = 2'(sent);
            v32 = 1;
            @(negedge clk);
            if (rdy32) sent++;
            cyc++;
        end
        @(posedge clk); #1;
        v32 = 0; ordy32 = 1;
        check("stream_sent", 32'(sent), 32'd10);
        cyc = 0;
        while (sb[0].size() != 0 && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("stream_drained", 32'(sb[0].size()), 32'd0);

        // Reset with three results in flight
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            a32 = 32'h0F00_000F << i; s32 = 5'(i + 1); m32 = 2'd0; v32 = 1;
        end
        @(posedge clk); #1;
        v32 = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_o_valid", {31'h0, ov32}, 32'd1);
        #1;
        pulse_reset();
        #1;
        check("mid_rst_o_valid", {31'h0, ov32}, 32'd0);
        check("mid_rst_o_y", oy32, 32'd0);
        #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        one32("post_rst_sra", 32'h8000_0001, 1, 2'd2, 32'hC000_0000);

        // N=8 exhaustive sweep, streamed back-to-back
        for (int a = 0; a < 256; a++)
            for (int s = 0; s < 8; s++)
                for (int m = 0; m < 4; m++) begin
                    @(posedge clk); #1;
                    a8 = 8'(a); s8 = 3'(s); m8 = 2'(m); v8 = 1;
                end
        @(posedge clk); #1;
        v8 = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("n8_last_valid", {31'h0, ov8}, 32'd1);
        check("n8_last_y", {24'h0, oy8}, 32'h0000_00FF);
        @(posedge clk); #1;
        check("n8_after_last", {31'h0, ov8}, 32'd0);
        check("n8_drained", 32'(sb[1].size()), 32'd0);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
